// File: rtl/nicnac16_ctrl_pkg.sv
// Shared control encodings for the NICNAC16 sequencer: states, opcodes, opcode classes.
package nicnac16_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_D = 3'd2,
        DECODE  = 3'd3,
        ADDR    = 3'd4,
        READ    = 3'd5,
        WRITE   = 3'd6,
        HALT    = 3'd7
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_JUMP  = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        CLS_NOP   = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_JUMP  = 2'd3
    } op_class_t;

endpackage

// File: rtl/bus_sequencer_opcode_class_decode.sv
// Combinational opcode classifier: 4-bit opcode -> 2-bit class plus halt flag.
module opcode_class_decode
    import nicnac16_ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output op_class_t  o_class,
    output logic       o_is_halt
);

    // Map opcode to class; HALT and every unlisted opcode classify as NOP.
    always_comb begin
        o_class   = CLS_NOP;
        o_is_halt = 1'b0;
        case (i_op)
            OP_LOAD:  o_class   = CLS_LOAD;
            OP_STORE: o_class   = CLS_STORE;
            OP_JUMP:  o_class   = CLS_JUMP;
            OP_HALT:  o_is_halt = 1'b1;
            default:  o_class   = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/bus_sequencer.sv
// NICNAC16 multi-cycle sequencer: fetch/decode/execute control, one-hot bus
// selects, register strobes and memory request handshake.
module bus_sequencer
    import nicnac16_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RUN,
    input  logic       MEM_READY,
    input  logic [3:0] IR_OP,
    output logic       SEL_A,
    output logic       SEL_B,
    output logic       SEL_C,
    output logic       SEL_D,
    output logic       MEM_REQ,
    output logic       MEM_WE,
    output logic       LD_MAR,
    output logic       LD_IR,
    output logic       LD_ACC,
    output logic       LD_PC,
    output logic       INC_PC,
    output logic       INSTR_DONE,
    output logic       HALTED,
    output logic [2:0] STATE
);

    state_t    r_state;
    state_t    w_next;
    op_class_t r_class;
    op_class_t w_dec_class;
    logic      w_is_halt;

    opcode_class_decode u_decode (
        .i_op      (IR_OP),
        .o_class   (w_dec_class),
        .o_is_halt (w_is_halt)
    );

    // State register; asynchronous reset returns to IDLE immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode class is captured in DECODE and steers ADDR/READ/WRITE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_class <= CLS_NOP;
        end else if (r_state == DECODE) begin
            r_class <= w_dec_class;
        end
    end

    // Next-state and output decode; selects/MEM_*/HALTED are Moore, strobes in wait states are Mealy on MEM_READY.
    always_comb begin
        w_next     = r_state;
        SEL_A      = 1'b0;
        SEL_B      = 1'b0;
        SEL_C      = 1'b0;
        SEL_D      = 1'b0;
        MEM_REQ    = 1'b0;
        MEM_WE     = 1'b0;
        LD_MAR     = 1'b0;
        LD_IR      = 1'b0;
        LD_ACC     = 1'b0;
        LD_PC      = 1'b0;
        INC_PC     = 1'b0;
        INSTR_DONE = 1'b0;
        HALTED     = 1'b0;
        case (r_state)
            IDLE: begin
                if (RUN) w_next = FETCH_A;
            end
            FETCH_A: begin
                SEL_A  = 1'b1;
                LD_MAR = 1'b1;
                w_next = FETCH_D;
            end
            FETCH_D: begin
                SEL_D   = 1'b1;
                MEM_REQ = 1'b1;
                if (MEM_READY) begin
                    LD_IR  = 1'b1;
                    INC_PC = 1'b1;
                    w_next = DECODE;
                end
            end
            DECODE: begin
                if (w_is_halt) begin
                    w_next = HALT;
                end else if (w_dec_class == CLS_NOP) begin
                    INSTR_DONE = 1'b1;
                    w_next     = RUN ? FETCH_A : IDLE;
                end else begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                SEL_B = 1'b1;
                case (r_class)
                    CLS_JUMP: begin
                        LD_PC      = 1'b1;
                        INSTR_DONE = 1'b1;
                        w_next     = RUN ? FETCH_A : IDLE;
                    end
                    CLS_LOAD: begin
                        LD_MAR = 1'b1;
                        w_next = READ;
                    end
                    CLS_STORE: begin
                        LD_MAR = 1'b1;
                        w_next = WRITE;
                    end
                    default: w_next = IDLE;
                endcase
            end
            READ: begin
                SEL_D   = 1'b1;
                MEM_REQ = 1'b1;
                if (MEM_READY) begin
                    LD_ACC     = 1'b1;
                    INSTR_DONE = 1'b1;
                    w_next     = RUN ? FETCH_A : IDLE;
                end
            end
            WRITE: begin
                SEL_C   = 1'b1;
                MEM_REQ = 1'b1;
                MEM_WE  = 1'b1;
                if (MEM_READY) begin
                    INSTR_DONE = 1'b1;
                    w_next     = RUN ? FETCH_A : IDLE;
                end
            end
            HALT: begin
                HALTED = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    assign STATE = r_state;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle output trace, which is then replayed.
module tb_bus_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RUN = 1'b0;
    logic       MEM_READY = 1'b0;
    logic [3:0] IR_OP = 4'h0;
    logic       SEL_A, SEL_B, SEL_C, SEL_D;
    logic       MEM_REQ, MEM_WE;
    logic       LD_MAR, LD_IR, LD_ACC, LD_PC, INC_PC;
    logic       INSTR_DONE, HALTED;
    logic [2:0] STATE;

    bus_sequencer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RUN        (RUN),
        .MEM_READY  (MEM_READY),
        .IR_OP      (IR_OP),
        .SEL_A      (SEL_A),
        .SEL_B      (SEL_B),
        .SEL_C      (SEL_C),
        .SEL_D      (SEL_D),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .LD_MAR     (LD_MAR),
        .LD_IR      (LD_IR),
        .LD_ACC     (LD_ACC),
        .LD_PC      (LD_PC),
        .INC_PC     (INC_PC),
        .INSTR_DONE (INSTR_DONE),
        .HALTED     (HALTED),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    // Output bit flags: {STATE[2:0], these 13 bits}
    localparam logic [12:0] B_HLT = 13'h1000;
    localparam logic [12:0] B_DN  = 13'h0800;
    localparam logic [12:0] B_SA  = 13'h0400;
    localparam logic [12:0] B_SB  = 13'h0200;
    localparam logic [12:0] B_SC  = 13'h0100;
    localparam logic [12:0] B_SD  = 13'h0080;
    localparam logic [12:0] B_RQ  = 13'h0040;
    localparam logic [12:0] B_WE  = 13'h0020;
    localparam logic [12:0] B_MAR = 13'h0010;
    localparam logic [12:0] B_IR  = 13'h0008;
    localparam logic [12:0] B_ACC = 13'h0004;
    localparam logic [12:0] B_PC  = 13'h0002;
    localparam logic [12:0] B_INC = 13'h0001;

    typedef struct packed {
        logic [15:0] exp;
        logic        run;
        logic        rdy;
        logic [3:0]  op;
    } step_t;

    step_t q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    n_cyc = 0;
    bit    running = 1'b0;
    bit    halted_m = 1'b0;

    function automatic logic [15:0] ev(input logic [2:0] st, input logic [12:0] b);
        return {st, b};
    endfunction

    function automatic logic [15:0] observed();
        return {STATE, HALTED, INSTR_DONE, SEL_A, SEL_B, SEL_C, SEL_D,
                MEM_REQ, MEM_WE, LD_MAR, LD_IR, LD_ACC, LD_PC, INC_PC};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    task automatic push(input logic [15:0] e, input logic run, input logic rdy, input logic [3:0] op);
        step_t s;
        s.exp = e; s.run = run; s.rdy = rdy; s.op = op;
        q.push_back(s);
    endtask

    // k idle cycles with RUN low, then one with RUN high to launch the fetch.
    task automatic emit_idle(input int k);
        for (int i = 0; i < k; i++) push(ev(3'd0, '0), 1'b0, rb(), rop());
        push(ev(3'd0, '0), 1'b1, rb(), rop());
    endtask

    // Expected cycle trace of one instruction, from the opcode class rules.
    task automatic gen_instr(input logic [3:0] op, input int fdw, input int exw, input logic run_after);
        if (!running) emit_idle($urandom_range(0, 2));
        push(ev(3'd1, B_SA | B_MAR), rb(), rb(), rop());
        for (int i = 0; i < fdw; i++) push(ev(3'd2, B_SD | B_RQ), rb(), 1'b0, rop());
        push(ev(3'd2, B_SD | B_RQ | B_IR | B_INC), rb(), 1'b1, rop());
        if (op == 4'hF) begin
            push(ev(3'd3, '0), rb(), rb(), op);
            for (int i = 0; i < 20; i++) push(ev(3'd7, B_HLT), rb(), rb(), rop());
            halted_m = 1'b1;
        end else if (op == 4'h3) begin
            push(ev(3'd3, '0), rb(), rb(), op);
            push(ev(3'd4, B_SB | B_PC | B_DN), run_after, rb(), rop());
        end else if (op == 4'h1) begin
            push(ev(3'd3, '0), rb(), rb(), op);
            push(ev(3'd4, B_SB | B_MAR), rb(), rb(), rop());
            for (int i = 0; i < exw; i++) push(ev(3'd5, B_SD | B_RQ), rb(), 1'b0, rop());
            push(ev(3'd5, B_SD | B_RQ | B_ACC | B_DN), run_after, 1'b1, rop());
        end else if (op == 4'h2) begin
            push(ev(3'd3, '0), rb(), rb(), op);
            push(ev(3'd4, B_SB | B_MAR), rb(), rb(), rop());
            for (int i = 0; i < exw; i++) push(ev(3'd6, B_SC | B_RQ | B_WE), rb(), 1'b0, rop());
            push(ev(3'd6, B_SC | B_RQ | B_WE | B_DN), run_after, 1'b1, rop());
        end else begin
            push(ev(3'd3, B_DN), run_after, rb(), op);
        end
        running = run_after;
    endtask

    function automatic logic [3:0] nop_op();
        logic [3:0] o;
        do o = 4'($urandom); while (o inside {4'h1, 4'h2, 4'h3, 4'hF});
        return o;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, n_cyc, obs, exp);
        end
    endtask

    // Replay up to n queued steps: drive at negedge, sample 1ns later.
    task automatic run_steps(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge CLK);
            RUN = s.run; MEM_READY = s.rdy; IR_OP = s.op;
            #1;
            n_cyc++;
            check("trace", observed(), s.exp);
        end
    endtask

    initial begin
        logic [3:0] op;
        int         c;
        // Outputs are zero throughout reset, whatever the inputs.
        RUN = 1'b1; MEM_READY = 1'b1; IR_OP = 4'h1;
        @(negedge CLK); #1;
        check("reset_hold", observed(), '0);
        @(negedge CLK); #1;
        check("reset_hold2", observed(), '0);
        RUN = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        // Reach READ with memory stalled, then assert reset between edges.
        emit_idle(0);
        running = 1'b1;
        gen_instr(4'h1, 0, 3, 1'b1);
        run_steps(6);
        check("in_read", observed(), ev(3'd5, B_SD | B_RQ));
        #2 RST_N = 1'b0;
        #1 check("async_reset_drop", observed(), '0);
        q.delete();
        RUN = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        running = 1'b0;

        // Directed opening sequence, then random instructions, then HALT.
        emit_idle(0);
        running = 1'b1;
        gen_instr(4'h0, 0, 0, 1'b1);
        gen_instr(4'h1, 0, 2, 1'b1);
        gen_instr(4'h2, 1, 1, 1'b1);
        gen_instr(4'h3, 0, 0, 1'b1);
        gen_instr(4'h1, 1, 1, 1'b0);
        gen_instr(nop_op(), 2, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 3);
            case (c)
                0: op = nop_op();
                1: op = 4'h1;
                2: op = 4'h2;
                default: op = 4'h3;
            endcase
            gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0));
        end
        gen_instr(4'hF, 1, 0, 1'b1);
        run_steps(100000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
